video_scale_near_v3: RTL and testbench

Single-clock, parametrised nearest-neighbour video scaler. It is the successor to the two-clock near scaler. It accepts a pixel stream with valid/ready flow control and stores it in a ping-pong pair of line buffers, so input line N+1 is written while output rows sourced from line N are read. Scale factors are computed by an on-block sequential divider at each frame start. Output is a valid/ready stream with start-of-frame and end-of-line markers.

---
 rtl/video_scale_near_v3.sv | 242 ++++++++++++++++++++++++
 tb/tb_video_scale_near_v3.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/video_scale_near_v3.sv
// Single-clock nearest-neighbour scaler: ping-pong line buffers, sequential scale divider, skid-buffered output.
// Optional horizontal mirroring is enabled by defining VSCALE_MIRROR_EN (adds the h_mirror input).
module video_scale_near_v3 #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11,
  parameter int RES_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic              vout_clk,
  input  logic              rst,
  input  logic              frame_start,
`ifdef VSCALE_MIRROR_EN
  input  logic              h_mirror,
`endif
  input  logic [RES_W-1:0]  vin_xres,
  input  logic [RES_W-1:0]  vin_yres,
  input  logic [RES_W-1:0]  vout_xres,
  input  logic [RES_W-1:0]  vout_yres,
  input  logic [DATA_W-1:0] vin_dat,
  input  logic              vin_valid,
  output logic              vin_ready,
  output logic [DATA_W-1:0] vout_dat,
  output logic              vout_valid,
  input  logic              vout_ready,
  output logic              vout_sof,
  output logic              vout_eol,
  output logic              busy,
  output logic              cfg_err
);
  localparam int Q_W   = RES_W + FRAC_W;
  localparam int CNT_W = $clog2(Q_W + 1);
  localparam logic [RES_W:0] MAX_X = (RES_W+1)'(1) << ADDR_W;

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [RES_W-1:0]  xres_in, yres_in, xres_out, yres_out;
  logic              cfg_chk, cfg_bad, cfg_fail;
  logic [Q_W-1:0]    div_num, div_q, scale_x, scale_y;
  logic [RES_W-1:0]  div_rem, div_den, div_rem_nxt;
  logic [RES_W:0]    div_sh, div_sub;
  logic              div_ge, div_last;
  logic [CNT_W-1:0]  div_cnt;
  logic [RES_W-1:0]  ix, iy, ox, oy, sx, sy, rd_idx;
  logic [Q_W-1:0]    acc_x, acc_y;
  logic              wr_en, issue_p0, sof_p0, eol_p0, pop;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              vld_p1, sof_p1, eol_p1;
  logic [DATA_W-1:0] dat_p1;
  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];
  logic [DATA_W-1:0] fifo_dat [0:1];
  logic              fifo_sof [0:1];
  logic              fifo_eol [0:1];
  logic              fifo_wp, fifo_rp;
  logic [1:0]        fifo_cnt, occ;
`ifdef VSCALE_MIRROR_EN
  logic              mirror_q;
`endif

  function automatic logic [RES_W-1:0] clamp_idx(input logic [RES_W-1:0] idx,
                                                 input logic [RES_W-1:0] res);
    return (idx >= res) ? res - RES_W'(1) : idx;
  endfunction

  assign cfg_bad = (xres_in == '0) || (yres_in == '0) || (xres_out == '0) || (yres_out == '0) ||
                   ({1'b0, xres_in} > MAX_X) || ({1'b0, xres_out} > MAX_X);
  assign cfg_fail = (state == DIV_X) && cfg_chk && cfg_bad;

  // Restoring divider step: the dividend register doubles as the quotient shift register
  assign div_den     = (state == DIV_X) ? xres_out : yres_out;
  assign div_sh      = {div_rem, div_num[Q_W-1]};
  assign div_sub     = div_sh - {1'b0, div_den};
  assign div_ge      = (div_sh >= {1'b0, div_den});
  assign div_rem_nxt = div_ge ? RES_W'(div_sub) : RES_W'(div_sh);
  assign div_q       = {div_num[Q_W-2:0], div_ge};
  assign div_last    = (div_cnt == CNT_W'(Q_W - 1));

  assign sx = clamp_idx(acc_x[Q_W-1:FRAC_W], xres_in);
  assign sy = clamp_idx(acc_y[Q_W-1:FRAC_W], yres_in);

  // Write side never gets more than one line ahead of the row being read
  assign vin_ready = ((state == RUN) || (state == DRAIN)) && (iy < yres_in) &&
                     ({1'b0, iy} <= ({1'b0, sy} + (RES_W+1)'(1)));
  assign wr_en     = vin_valid && vin_ready;

  assign vout_valid = (fifo_cnt != 2'd0);
  assign pop        = vout_valid && vout_ready;
  assign occ        = fifo_cnt + {1'b0, vld_p1};
  assign issue_p0   = (state == RUN) && (oy < yres_out) && (iy > sy) &&
                      ((occ < 2'd2) || pop);
  assign sof_p0     = (ox == '0) && (oy == '0);
  assign eol_p0     = (ox == xres_out - RES_W'(1));

`ifdef VSCALE_MIRROR_EN
  assign rd_idx = mirror_q ? (xres_in - RES_W'(1) - sx) : sx;
`else
  assign rd_idx = sx;
`endif
  assign rd_addr_p0 = ADDR_W'(rd_idx);

  assign vout_dat = vout_valid ? fifo_dat[fifo_rp] : '0;
  assign vout_sof = vout_valid && fifo_sof[fifo_rp];
  assign vout_eol = vout_valid && fifo_eol[fifo_rp];
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (frame_start) state_nxt = DIV_X;
    else begin
      case (state)
        DIV_X:   if (cfg_fail) state_nxt = IDLE;
                 else if (div_last) state_nxt = DIV_Y;
        DIV_Y:   if (div_last) state_nxt = RUN;
        RUN:     if (oy == yres_out) state_nxt = DRAIN;
        DRAIN:   if ((iy == yres_in) && (fifo_cnt == 2'd0) && !vld_p1) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      xres_in  <= '0;
      yres_in  <= '0;
      xres_out <= '0;
      yres_out <= '0;
      cfg_chk  <= 1'b0;
      cfg_err  <= 1'b0;
      div_num  <= '0;
      div_rem  <= '0;
      div_cnt  <= '0;
      scale_x  <= '0;
      scale_y  <= '0;
      ix       <= '0;
      iy       <= '0;
      ox       <= '0;
      oy       <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
`ifdef VSCALE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        xres_in  <= vin_xres;
        yres_in  <= vin_yres;
        xres_out <= vout_xres;
        yres_out <= vout_yres;
        cfg_chk  <= 1'b1;
        cfg_err  <= 1'b0;
        div_num  <= {vin_xres, FRAC_W'(0)};
        div_rem  <= '0;
        div_cnt  <= '0;
        ix       <= '0;
        iy       <= '0;
        ox       <= '0;
        oy       <= '0;
        acc_x    <= '0;
        acc_y    <= '0;
`ifdef VSCALE_MIRROR_EN
        mirror_q <= h_mirror;
`endif
      end else begin
        cfg_chk <= 1'b0;
        if (cfg_fail) cfg_err <= 1'b1;
        if ((state == DIV_X) || (state == DIV_Y)) begin
          div_num <= div_q;
          div_rem <= div_rem_nxt;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_last) begin
            div_rem <= '0;
            div_cnt <= '0;
            if (state == DIV_X) begin
              scale_x <= div_q;
              div_num <= {yres_in, FRAC_W'(0)};
            end else begin
              scale_y <= div_q;
            end
          end
        end
        if (wr_en) begin
          if (ix == xres_in - RES_W'(1)) begin
            ix <= '0;
            iy <= iy + RES_W'(1);
          end else begin
            ix <= ix + RES_W'(1);
          end
        end
        if (issue_p0) begin
          if (eol_p0) begin
            ox    <= '0;
            acc_x <= '0;
            acc_y <= acc_y + scale_y;
            oy    <= oy + RES_W'(1);
          end else begin
            ox    <= ox + RES_W'(1);
            acc_x <= acc_x + scale_x;
          end
        end
      end
    end
  end

  // p0 -> p1: line-buffer read, one cycle latency; write and read banks always differ
  always_ff @(posedge vout_clk) begin
    if (wr_en) mem[{iy[0], ADDR_W'(ix)}] <= vin_dat;
    dat_p1 <= mem[{sy[0], rd_addr_p0}];
    sof_p1 <= sof_p0;
    eol_p1 <= eol_p0;
  end

  // p1 -> skid buffer
  always_ff @(posedge vout_clk) begin
    if (vld_p1) begin
      fifo_dat[fifo_wp] <= dat_p1;
      fifo_sof[fifo_wp] <= sof_p1;
      fifo_eol[fifo_wp] <= eol_p1;
    end
  end

  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else if (frame_start) begin
      vld_p1   <= 1'b0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      vld_p1   <= issue_p0;
      if (vld_p1) fifo_wp <= ~fifo_wp;
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_video_scale_near_v3.sv
// Directed bench for video_scale_near_v3: scaling, flow control, config errors, abort.
`timescale 1ns/1ps
module tb_video_scale_near_v3;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 11;
  localparam int RES_W  = 16;
  localparam int FRAC_W = 16;

  logic              vout_clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
`ifdef VSCALE_MIRROR_EN
  logic              h_mirror = 1'b0;
`endif
  logic [RES_W-1:0]  vin_xres = '0, vin_yres = '0, vout_xres = '0, vout_yres = '0;
  logic [DATA_W-1:0] vin_dat = '0;
  logic              vin_valid = 1'b0;
  logic              vin_ready;
  logic [DATA_W-1:0] vout_dat;
  logic              vout_valid;
  logic              vout_ready = 1'b0;
  logic              vout_sof, vout_eol, busy, cfg_err;

  video_scale_near_v3 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RES_W(RES_W), .FRAC_W(FRAC_W)) dut (
    .vout_clk(vout_clk), .rst(rst), .frame_start(frame_start),
`ifdef VSCALE_MIRROR_EN
    .h_mirror(h_mirror),
`endif
    .vin_xres(vin_xres), .vin_yres(vin_yres), .vout_xres(vout_xres), .vout_yres(vout_yres),
    .vin_dat(vin_dat), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .vout_dat(vout_dat), .vout_valid(vout_valid), .vout_ready(vout_ready),
    .vout_sof(vout_sof), .vout_eol(vout_eol), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 vout_clk = ~vout_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] got_dat [0:255];
  logic              got_sof [0:255];
  logic              got_eol [0:255];
  int n_got, n_in, stall_viol;
  logic timed_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after frame_start was sampled
  task automatic start_frame(input int xi, input int yi, input int xo, input int yo);
    vin_valid   = 1'b0;
    vin_xres    = RES_W'(xi);
    vin_yres    = RES_W'(yi);
    vout_xres   = RES_W'(xo);
    vout_yres   = RES_W'(yo);
    frame_start = 1'b1;
    @(negedge vout_clk);
    frame_start = 1'b0;
  endtask

  // Drives pixels base+0.. and collects outputs until busy falls, budget expires or stop_after outputs
  task automatic drive_loop(input int xi, input int yi, input int base, input int vpct,
                            input int rpct, input int budget, input int stop_after);
    int k;
    int cyc;
    logic pstall, psof, peol;
    logic [DATA_W-1:0] pdat;
    k = 0; cyc = 0; pstall = 1'b0; psof = 1'b0; peol = 1'b0; pdat = '0;
    n_got = 0; stall_viol = 0; timed_out = 1'b0;
    while (busy && (cyc < budget) && (n_got != stop_after)) begin
      vout_ready = (int'($urandom_range(99)) < rpct);
      vin_valid  = (k < xi * yi) && (int'($urandom_range(99)) < vpct);
      vin_dat    = DATA_W'(base + k);
      if (pstall && (!vout_valid || (vout_dat !== pdat) || (vout_sof !== psof) || (vout_eol !== peol)))
        stall_viol++;
      if (vin_valid && vin_ready) k++;
      if (vout_valid && vout_ready) begin
        if (n_got < 256) begin
          got_dat[n_got] = vout_dat;
          got_sof[n_got] = vout_sof;
          got_eol[n_got] = vout_eol;
        end
        n_got++;
      end
      pstall = vout_valid && !vout_ready;
      pdat = vout_dat; psof = vout_sof; peol = vout_eol;
      @(negedge vout_clk);
      cyc++;
    end
    if (cyc >= budget) timed_out = 1'b1;
    n_in = k;
    vin_valid = 1'b0;
  endtask

  task automatic check_out(input string t, input int xi, input int yi, input int xo, input int yo);
    chk({t, "_count"}, 32'(n_got), 32'(xo * yo));
    for (int oy = 0; oy < yo; oy++) begin
      for (int ox = 0; ox < xo; ox++) begin
        int i;
        i = oy * xo + ox;
        chk($sformatf("%s_dat[%0d]", t, i), 32'(got_dat[i]), 32'(((oy * yi) / yo) * xi + (ox * xi) / xo));
        chk($sformatf("%s_sof[%0d]", t, i), 32'(got_sof[i]), 32'(i == 0));
        chk($sformatf("%s_eol[%0d]", t, i), 32'(got_eol[i]), 32'(ox == xo - 1));
      end
    end
  endtask

  initial begin
    // Reset
    @(negedge vout_clk);
    @(negedge vout_clk);
    chk("rst_vout_valid", 32'(vout_valid), 32'd0);
    chk("rst_vin_ready", 32'(vin_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_vout_sof", 32'(vout_sof), 32'd0);
    chk("rst_vout_eol", 32'(vout_eol), 32'd0);
    chk("rst_vout_dat", 32'(vout_dat), 32'd0);
    rst = 1'b0;
    @(negedge vout_clk);

    // 4x4 -> 8x8, free-running
    start_frame(4, 4, 8, 8);
    drive_loop(4, 4, 0, 100, 100, 2000, -1);
    chk("t1_timeout", 32'(timed_out), 32'd0);
    chk("t1_scale_x", dut.scale_x, 32'h0000_8000);
    chk("t1_scale_y", dut.scale_y, 32'h0000_8000);
    check_out("t1", 4, 4, 8, 8);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_cfg_err", 32'(cfg_err), 32'd0);
    chk("t1_inputs", 32'(n_in), 32'd16);

    // 8x4 -> 4x2 downscale
    @(negedge vout_clk);
    start_frame(8, 4, 4, 2);
    drive_loop(8, 4, 0, 100, 100, 2000, -1);
    chk("t2_timeout", 32'(timed_out), 32'd0);
    chk("t2_scale_x", dut.scale_x, 32'h0002_0000);
    chk("t2_scale_y", dut.scale_y, 32'h0002_0000);
    check_out("t2", 8, 4, 4, 2);
    chk("t2_inputs", 32'(n_in), 32'd32);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // 4x4 -> 8x8 with random backpressure and sparse input
    @(negedge vout_clk);
    start_frame(4, 4, 8, 8);
    drive_loop(4, 4, 0, 30, 50, 4000, -1);
    chk("t3_timeout", 32'(timed_out), 32'd0);
    check_out("t3", 4, 4, 8, 8);
    chk("t3_stall_stable", 32'(stall_viol), 32'd0);

    // Invalid configurations
    @(negedge vout_clk);
    start_frame(2049, 4, 4, 4);
    drive_loop(2049, 4, 0, 100, 100, 50, -1);
    @(negedge vout_clk);
    @(negedge vout_clk);
    chk("t4a_cfg_err", 32'(cfg_err), 32'd1);
    chk("t4a_busy", 32'(busy), 32'd0);
    chk("t4a_vin_ready", 32'(vin_ready), 32'd0);
    chk("t4a_no_output", 32'(n_got), 32'd0);
    start_frame(4, 4, 4, 0);
    drive_loop(4, 4, 0, 100, 100, 50, -1);
    @(negedge vout_clk);
    @(negedge vout_clk);
    chk("t4b_cfg_err", 32'(cfg_err), 32'd1);
    chk("t4b_busy", 32'(busy), 32'd0);
    chk("t4b_vin_ready", 32'(vin_ready), 32'd0);
    chk("t4b_no_output", 32'(n_got), 32'd0);

    // Abort mid-row, then a clean 2x2 -> 2x2 frame
    start_frame(4, 4, 8, 8);
    drive_loop(4, 4, 0, 100, 100, 2000, 3);
    chk("t5_reached_mid_row", 32'(n_got), 32'd3);
    chk("t5_pre_abort_valid", 32'(vout_valid), 32'd1);
    start_frame(2, 2, 2, 2);
    chk("t5_valid_dropped", 32'(vout_valid), 32'd0);
    chk("t5_cfg_err_cleared", 32'(cfg_err), 32'd0);
    drive_loop(2, 2, 0, 100, 100, 2000, -1);
    chk("t5_timeout", 32'(timed_out), 32'd0);
    check_out("t5", 2, 2, 2, 2);

`ifdef VSCALE_MIRROR_EN
    // Mirrored 4x1 -> 4x1
    @(negedge vout_clk);
    h_mirror = 1'b1;
    start_frame(4, 1, 4, 1);
    h_mirror = 1'b0;
    drive_loop(4, 1, 10, 100, 100, 2000, -1);
    chk("t6_timeout", 32'(timed_out), 32'd0);
    chk("t6_count", 32'(n_got), 32'd4);
    chk("t6_dat0", 32'(got_dat[0]), 32'd13);
    chk("t6_dat1", 32'(got_dat[1]), 32'd12);
    chk("t6_dat2", 32'(got_dat[2]), 32'd11);
    chk("t6_dat3", 32'(got_dat[3]), 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
